// File: rtl/bus_source_sel.sv
// Registered one-of-NSRC bus source selector with deterministic conflict resolution.
// Optional bus keeper on idle cycles: define BUS_SOURCE_SEL_KEEPER_EN.
module bus_source_sel #(
    parameter int WIDTH = 9,
    parameter int NSRC  = 11,
    parameter int OW    = $clog2(NSRC),
    parameter int CNTW  = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC-1:0]       src_out,
    input  logic                  clr_err,
    output logic [WIDTH-1:0]      BUS,
    output logic                  bus_valid,
    output logic [OW-1:0]         owner,
    output logic                  conflict,
    output logic                  conflict_sticky,
    output logic [CNTW-1:0]       conflict_cnt
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [NSRC-1:0] ONE     = {{(NSRC-1){1'b0}}, 1'b1};

    // Strobe protocol: src_out bits are sampled every rising edge with no
    // handshake; the selected word is on BUS one cycle later, never stalled.

    logic              any_sel;
    logic              multi_sel;
    logic [OW-1:0]     win_idx;
    logic [WIDTH-1:0]  win_data;

    logic [WIDTH-1:0]  bus_q, bus_d;
    logic              valid_q, valid_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic              conflict_q, conflict_d;
    logic              sticky_q, sticky_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    // Downward scan so the lowest set strobe is the last assignment and wins.
    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (src_out[i]) begin
                win_idx  = OW'(i);
                win_data = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign any_sel   = |src_out;
    assign multi_sel = |(src_out & (src_out - ONE));

    always_comb begin
        bus_d      = bus_q;
        valid_d    = 1'b0;
        owner_d    = owner_q;
        conflict_d = 1'b0;
        sticky_d   = sticky_q;
        cnt_d      = cnt_q;

        if (any_sel) begin
            bus_d   = win_data;
            owner_d = win_idx;
            valid_d = 1'b1;
        end else begin
`ifdef BUS_SOURCE_SEL_KEEPER_EN
            bus_d = bus_q;
`else
            bus_d = '0;
`endif
        end

        // A conflict in the same cycle as clr_err restarts the record at one event.
        if (multi_sel) begin
            conflict_d = 1'b1;
            sticky_d   = 1'b1;
            if (clr_err) begin
                cnt_d = {{(CNTW-1){1'b0}}, 1'b1};
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
            end
        end else if (clr_err) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            bus_q      <= '0;
            valid_q    <= 1'b0;
            owner_q    <= '0;
            conflict_q <= 1'b0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            bus_q      <= bus_d;
            valid_q    <= valid_d;
            owner_q    <= owner_d;
            conflict_q <= conflict_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
        end
    end

    assign BUS             = bus_q;
    assign bus_valid       = valid_q;
    assign owner           = owner_q;
    assign conflict        = conflict_q;
    assign conflict_sticky = sticky_q;
    assign conflict_cnt    = cnt_q;

endmodule

// File: tb/tb_bus_source_sel.sv
// Self-checking bench for bus_source_sel: default instance against a behavioural
// model, plus a WIDTH=16/NSRC=32 instance for the one-hot walk.
module tb_bus_source_sel;

    localparam int W  = 9;
    localparam int N  = 11;
    localparam int OW = $clog2(N);
    localparam int CW = 8;
    localparam int W2 = 16;
    localparam int N2 = 32;

    logic              Clock = 1'b0;
    logic              Reset;
    logic [N*W-1:0]    src_data;
    logic [N-1:0]      src_out;
    logic              clr_err;
    logic [W-1:0]      bus_o;
    logic              bus_valid;
    logic [OW-1:0]     owner;
    logic              conflict;
    logic              conflict_sticky;
    logic [CW-1:0]     conflict_cnt;

    logic [N2*W2-1:0]  w_src_data;
    logic [N2-1:0]     w_src_out;
    logic              w_clr_err;
    logic [W2-1:0]     w_bus;
    logic              w_bus_valid;
    logic [4:0]        w_owner;
    logic              w_conflict;
    logic              w_sticky;
    logic [CW-1:0]     w_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural reference state
    logic [W-1:0]  exp_bus;
    logic          exp_valid;
    logic [OW-1:0] exp_owner;
    logic          exp_conf;
    logic          exp_sticky;
    int            exp_cnt;

    always #5 Clock = ~Clock;

    bus_source_sel dut (
        .Clock(Clock), .Reset(Reset), .src_data(src_data), .src_out(src_out),
        .clr_err(clr_err), .BUS(bus_o), .bus_valid(bus_valid), .owner(owner),
        .conflict(conflict), .conflict_sticky(conflict_sticky), .conflict_cnt(conflict_cnt)
    );

    bus_source_sel #(.WIDTH(W2), .NSRC(N2)) dut_w (
        .Clock(Clock), .Reset(Reset), .src_data(w_src_data), .src_out(w_src_out),
        .clr_err(w_clr_err), .BUS(w_bus), .bus_valid(w_bus_valid), .owner(w_owner),
        .conflict(w_conflict), .conflict_sticky(w_sticky), .conflict_cnt(w_cnt)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int i, input logic [W-1:0] v);
        src_data[i*W +: W] = v;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) src_data[i*W +: W] = W'($urandom);
    endtask

    // Model: applies the selection rules to the inputs sampled at this edge.
    task automatic model_step();
        int n;
        int idx;
        logic [N-1:0] lowest;
        if (Reset) begin
            exp_bus = '0; exp_valid = 0; exp_owner = '0;
            exp_conf = 0; exp_sticky = 0; exp_cnt = 0;
        end else begin
            n = $countones(src_out);
            if (n == 0) begin
                exp_valid = 0;
                exp_conf  = 0;
`ifndef BUS_SOURCE_SEL_KEEPER_EN
                exp_bus = '0;
`endif
            end else begin
                lowest    = src_out & (~src_out + 1'b1);
                idx       = $clog2(lowest);
                exp_bus   = W'(src_data >> (idx * W));
                exp_owner = OW'(idx);
                exp_valid = 1;
                exp_conf  = (n > 1);
            end
            if (n > 1) begin
                exp_sticky = 1;
                exp_cnt    = clr_err ? 1 : ((exp_cnt < 255) ? exp_cnt + 1 : 255);
            end else if (clr_err) begin
                exp_sticky = 0;
                exp_cnt    = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".bus"},   32'(bus_o),        32'(exp_bus));
        check_bit({tag, ".valid"}, bus_valid,          exp_valid);
        check_val({tag, ".owner"}, 32'(owner),        32'(exp_owner));
        check_bit({tag, ".conf"},  conflict,           exp_conf);
        check_bit({tag, ".stky"},  conflict_sticky,    exp_sticky);
        check_val({tag, ".cnt"},   32'(conflict_cnt), 32'(exp_cnt));
    endtask

    // One clock: inputs already driven; model at the edge, check #1 after.
    task automatic cyc(input string tag);
        @(posedge Clock);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        Reset = 1; src_out = '0; clr_err = 0; src_data = '0;
        w_src_data = '0; w_src_out = '0; w_clr_err = 0;
        exp_cnt = 0;
        #1;
        cyc("rst0");
        cyc("rst1");
        check_val("rst_const.bus", 32'(bus_o), 32'h0);
        check_val("rst_const.cnt", 32'(conflict_cnt), 32'h0);
        Reset = 0;

        // Single select of source 3
        rand_data(); set_word(3, 9'h0A5); src_out = N'(1 << 3);
        cyc("single3");
        check_val("single3_const", 32'(bus_o), 32'h0A5);

        // Source 2 then idle
        set_word(2, 9'h011); src_out = N'(1 << 2);
        cyc("single2");
        src_out = '0; rand_data();
        cyc("idle");
        check_val("idle_owner_const", 32'(owner), 32'd2);

        // Multi: bits 5 and 9
        rand_data(); set_word(5, 9'h1FF); src_out = N'((1 << 5) | (1 << 9));
        cyc("multi59");
        check_val("multi59_cnt_const", 32'(conflict_cnt), 32'd1);
        src_out = N'(1 << 7);
        cyc("after_multi");

        // Saturation
        for (int k = 0; k < 300; k++) begin
            rand_data(); src_out = N'((1 << 5) | (1 << 9));
            cyc("sat");
        end
        check_val("sat_const", 32'(conflict_cnt), 32'd255);
        src_out = N'(1 << 1); clr_err = 1;
        cyc("clr_single");
        clr_err = 0;

        // clr_err together with MULTI, then climb to 4
        src_out = N'((1 << 0) | (1 << 10)); clr_err = 1;
        cyc("clr_multi");
        clr_err = 0;
        for (int k = 0; k < 3; k++) begin
            rand_data(); src_out = N'(3 << k);
            cyc("climb");
        end
        check_val("climb_const", 32'(conflict_cnt), 32'd4);
        Reset = 1; clr_err = 1; src_out = N'((1 << 4) | (1 << 6));
        cyc("rst_multi");
        Reset = 0; clr_err = 0; src_out = '0;
        cyc("post_rst");

        // Wide instance: one-hot walk across 32 sources
        for (int i = 0; i < N2; i++) begin
            for (int j = 0; j < N2; j++) w_src_data[j*W2 +: W2] = W2'($urandom);
            w_src_data[i*W2 +: W2] = 16'h8000 | 16'(i);
            w_src_out = 32'(1) << i;
            cyc("walk_main");
            check_val("walk.bus", 32'(w_bus), 32'h8000 | 32'(i));
            check_val("walk.owner", 32'(w_owner), 32'(i));
            check_bit("walk.valid", w_bus_valid, 1'b1);
            check_bit("walk.conf", w_conflict, 1'b0);
        end
        w_src_out = '0;

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            rand_data();
            case ($urandom_range(0, 3))
                0: src_out = '0;
                1: src_out = N'(1) << $urandom_range(0, N - 1);
                2: src_out = (N'(1) << $urandom_range(0, N - 1)) | (N'(1) << $urandom_range(0, N - 1));
                default: src_out = N'($urandom);
            endcase
            clr_err = ($urandom_range(0, 9) == 0);
            Reset   = ($urandom_range(0, 39) == 0);
            cyc("rand");
        end
        Reset = 0; clr_err = 0; src_out = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
